// File: rtl/addn_pkg.sv
// Shared helpers for the pipelined adder/subtractor.
// Holds slice sizing and the parameter sanity check.
package addn_pkg;

    function automatic int slice_w(int width, int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    function automatic bit cfg_ok(int width, int stages);
        return (stages >= 1) && (stages <= width) && (width % stages == 0);
    endfunction

endpackage

// File: rtl/addn_slice.sv
// One registered SW-bit slice of the ripple-per-clock adder.
// Captures partial sum, carry and the transaction valid bit.
module addn_slice
    import addn_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          prev_valid,
    input  logic          prev_carry,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    output logic [SW-1:0] sum,
    output logic          carry,
    output logic          valid
);

    logic [SW:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, prev_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
            valid <= 1'b0;
        end else if (en) begin
            sum   <= total[SW-1:0];
            carry <= total[SW];
            valid <= prev_valid;
        end
    end

endmodule

// File: rtl/addn_pipeline.sv
// Pipelined N-bit adder/subtractor, one carry slice per clock.
// Global-enable valid/ready pipeline with full backpressure.
module addn_pipeline
    import addn_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] cina,
    input  logic [WIDTH-1:0] cinb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW  = slice_w(WIDTH, STAGES);
    localparam int MSB = WIDTH - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("addn_pipeline: WIDTH must be a positive multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             a_msb;
    logic             b_msb;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~cinb : cinb;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed by lower stages
        localparam int RW = WIDTH - k * SW;

        logic [RW-1:0] a_in;
        logic [RW-1:0] b_in;
        logic          carry_in;
        logic          valid_in;
        logic [SW-1:0] s;
        logic          c;
        logic          v;

        if (k == 0) begin : g_head
            assign a_in     = cina;
            assign b_in     = b_eff;
            assign carry_in = cin ^ sub;
            assign valid_in = in_valid;
        end else begin : g_body
            always_ff @(posedge clk_100M or negedge rst_n) begin
                if (!rst_n) begin
                    a_in <= '0;
                    b_in <= '0;
                end else if (adv) begin
                    a_in <= g_stage[k-1].a_in[RW+SW-1:SW];
                    b_in <= g_stage[k-1].b_in[RW+SW-1:SW];
                end
            end
            assign carry_in = g_stage[k-1].c;
            assign valid_in = g_stage[k-1].v;
        end

        // Completed lower result slices travel alongside the transaction
        if (k == 1) begin : g_lo
            logic [SW-1:0] lo;
            always_ff @(posedge clk_100M or negedge rst_n) begin
                if (!rst_n) lo <= '0;
                else if (adv) lo <= g_stage[0].s;
            end
        end else if (k > 1) begin : g_lo
            logic [k*SW-1:0] lo;
            always_ff @(posedge clk_100M or negedge rst_n) begin
                if (!rst_n) lo <= '0;
                else if (adv) lo <= {g_stage[k-1].s, g_stage[k-1].g_lo.lo};
            end
        end

        addn_slice #(.SW(SW)) u_slice (
            .clk        (clk_100M),
            .rst_n      (rst_n),
            .en         (adv),
            .prev_valid (valid_in),
            .prev_carry (carry_in),
            .a          (a_in[SW-1:0]),
            .b          (b_in[SW-1:0]),
            .sum        (s),
            .carry      (c),
            .valid      (v)
        );
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (adv) begin
            a_msb <= g_stage[STAGES-1].a_in[SW-1];
            b_msb <= g_stage[STAGES-1].b_in[SW-1];
        end
    end

    if (STAGES == 1) begin : g_out
        assign sum = g_stage[0].s;
    end else begin : g_out
        assign sum = {g_stage[STAGES-1].s, g_stage[STAGES-1].g_lo.lo};
    end

    assign cout      = g_stage[STAGES-1].c;
    assign out_valid = g_stage[STAGES-1].v;
    assign ovf       = (a_msb == b_msb) && (sum[MSB] != a_msb);

endmodule

// File: tb/tb_addn_pipeline.sv
// Randomised and directed bench for addn_pipeline (8/2 and 32/4).
// Expected results come from an integer arithmetic model.
module tb_addn_pipeline;

    localparam int S8 = 2;

    logic        clk = 1'b0;
    logic        rst_n8, rst_n32;
    logic        iv8, ir8, sub8, cin8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, sum8;
    logic        iv32, ir32, sub32, cin32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, sum32;

    int n_chk = 0;
    int n_pass = 0;

    logic [33:0] q8[$];
    logic [33:0] q32[$];
    bit          sb8 = 0;
    bit          sb32 = 0;
    bit          held8 = 0;
    bit          held32 = 0;
    logic [33:0] hv8, hv32;
    int          streak8 = 0;
    int          max8 = 0;
    bit          done32 = 0;

    always #5 clk = ~clk;

    addn_pipeline #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk_100M(clk), .rst_n(rst_n8), .in_valid(iv8), .in_ready(ir8),
        .sub(sub8), .cin(cin8), .cina(a8), .cinb(b8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(co8), .ovf(of8)
    );

    addn_pipeline #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk_100M(clk), .rst_n(rst_n32), .in_valid(iv32), .in_ready(ir32),
        .sub(sub32), .cin(cin32), .cina(a32), .cinb(b32),
        .out_valid(ov32), .out_ready(or32), .sum(sum32), .cout(co32), .ovf(of32)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Returns {ovf, cout, sum} from plain signed/unsigned integer arithmetic
    function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b,
                                          logic s, logic c);
        longint ua, ub, sa, sb, ci, r, sr, lim;
        logic co, of;
        logic [31:0] res;
        ua  = longint'(a);
        ub  = longint'(b);
        ci  = c ? 64'sd1 : 64'sd0;
        lim = longint'(1) << w;
        sa  = a[w-1] ? ua - lim : ua;
        sb  = b[w-1] ? ub - lim : ub;
        r   = s ? ua - ub - ci : ua + ub + ci;
        co  = s ? (r >= 0) : (r >= lim);
        sr  = s ? sa - sb - ci : sa + sb + ci;
        of  = (sr >= lim / 2) || (sr < -(lim / 2));
        res = 32'(r & (lim - 1));
        return {of, co, res};
    endfunction

    always @(negedge clk) begin
        if (sb8) begin
            if (held8) check("hold8", {of8, co8, 24'd0, sum8}, hv8);
            held8 = 0;
            if (ov8 && or8) begin
                streak8++;
                if (streak8 > max8) max8 = streak8;
                if (q8.size() == 0) check("extra8", 1, 0);
                else check("res8", {of8, co8, 24'd0, sum8}, q8.pop_front());
            end else if (ov8) begin
                held8 = 1;
                hv8 = {of8, co8, 24'd0, sum8};
            end else begin
                streak8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (sb32) begin
            if (!rst_n32) begin
                held32 = 0;
            end else begin
                if (held32) check("hold32", {of32, co32, sum32}, hv32);
                held32 = 0;
                if (ov32 && or32) begin
                    if (q32.size() == 0) check("extra32", 1, 0);
                    else check("res32", {of32, co32, sum32}, q32.pop_front());
                end else if (ov32) begin
                    held32 = 1;
                    hv32 = {of32, co32, sum32};
                end
            end
        end
    end

    task automatic single8(logic [7:0] a, logic [7:0] b, logic s, logic c,
                           logic [7:0] es, logic ec, logic eo);
        @(posedge clk); #1;
        iv8 = 1; a8 = a; b8 = b; sub8 = s; cin8 = c;
        @(negedge clk);
        check("rdy8", ir8, 1);
        @(posedge clk); #1;
        iv8 = 0;
        for (int i = 1; i < S8; i++) begin
            @(negedge clk);
            check("lat8", ov8, 0);
            @(posedge clk);
        end
        @(negedge clk);
        check("vld8", ov8, 1);
        check("sum8", sum8, es);
        check("cout8", co8, ec);
        check("ovf8", of8, eo);
    endtask

    task automatic send8(logic [7:0] a, logic [7:0] b, logic s, logic c);
        iv8 = 1; a8 = a; b8 = b; sub8 = s; cin8 = c;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ir8) begin
                q8.push_back(model(8, {24'd0, a}, {24'd0, b}, s, c));
                @(posedge clk); #1;
                iv8 = 0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send8_timeout", 0, 1);
        iv8 = 0;
    endtask

    task automatic send32(logic [31:0] a, logic [31:0] b, logic s, logic c);
        iv32 = 1; a32 = a; b32 = b; sub32 = s; cin32 = c;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ir32) begin
                q32.push_back(model(32, a, b, s, c));
                @(posedge clk); #1;
                iv32 = 0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send32_timeout", 0, 1);
        iv32 = 0;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n8 = 0; rst_n32 = 0;
        iv8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0; or8 = 1;
        iv32 = 0; sub32 = 0; cin32 = 0; a32 = 0; b32 = 0; or32 = 1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_vld8", ov8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", co8, 0);
        check("rst_ovf8", of8, 0);
        check("rst_vld32", ov32, 0);
        check("rst_sum32", sum32, 0);
        @(posedge clk); #1;
        rst_n8 = 1; rst_n32 = 1;
        @(negedge clk);
        check("rst_rdy8", ir8, 1);
        check("rst_rdy32", ir32, 1);

        single8(8'd255, 8'd100, 0, 0, 8'd99,  1, 0);
        single8(8'd100, 8'd100, 0, 1, 8'd201, 0, 1);
        single8(8'd150, 8'd150, 0, 1, 8'd45,  1, 1);
        single8(8'd100, 8'd150, 1, 0, 8'd206, 0, 1);
        single8(8'd5,   8'd3,   1, 1, 8'd1,   1, 0);
        single8(8'h80,  8'h01,  1, 0, 8'h7F,  1, 1);

        repeat (3) @(posedge clk);
        #1;
        sb8 = 1;
        max8 = 0;
        for (int i = 0; i < 9; i++)
            send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int t = 0; t < 50 && q8.size() > 0; t++) @(posedge clk);
        check("drain_stream8", q8.size(), 0);
        check("streak8", max8, 9);

        @(posedge clk); #1;
        or8 = 0;
        send8(8'd17, 8'd200, 0, 1);
        send8(8'd90, 8'd91, 1, 0);
        fork
            send8(8'd128, 8'd128, 0, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_rdy8", ir8, 0);
                end
                @(posedge clk); #1;
                or8 = 1;
            end
        join
        for (int t = 0; t < 50 && q8.size() > 0; t++) @(posedge clk);
        check("drain_bp8", q8.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        sb8 = 0;

        sb32 = 1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if (i == 600) begin
                        rst_n32 = 0;
                        q32.delete();
                        @(negedge clk);
                        check("mid_rst_vld32", ov32, 0);
                        check("mid_rst_sum32", sum32, 0);
                        @(posedge clk); #1;
                        rst_n32 = 1;
                        repeat (5) begin
                            @(negedge clk);
                            check("no_stale32", ov32, 0);
                        end
                        @(posedge clk); #1;
                    end
                    send32(pick32(), pick32(), 1'($urandom), 1'($urandom));
                end
                done32 = 1;
            end
            begin
                while (!done32) begin
                    @(posedge clk); #1;
                    or32 = ($urandom_range(0, 3) != 0);
                end
                or32 = 1;
            end
        join
        for (int t = 0; t < 100 && q32.size() > 0; t++) @(posedge clk);
        check("drain32", q32.size(), 0);
        repeat (2) @(posedge clk);
        sb32 = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
